ab_compare_tracker: RTL
=======================

# ab_compare_tracker

Downstream consumer of the a/b operand stage: samples the two 4-bit operand streams, classifies each valid sample as pass (a>b), equal, or fail (a<b), and keeps saturating statistics. Change-of-result and equality events go into a small show-ahead FIFO drained over a valid/ready handshake. It turns the per-sample pass/fail/equal decisions of the operand stage into registered counts and a buffered event log that downstream logic or a bench scoreboard can consume.

## Interface
- WIDTH, 4, operand width in bits
- DEPTH, 4, event FIFO depth in entries; power of two, ≥2
- CNT_W, 8, width of each statistics counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  a/b sample valid this cycle
- a  in  WIDTH  operand a, unsigned
- b  in  WIDTH  operand b, unsigned
- clear  in  1  synchronous clear of counters, overflow, history and FIFO
- out_valid  out  1  FIFO head entry valid
- out_ready  in  1  consumer accepts head entry
- out_data  out  2*WIDTH+2  {code[1:0], a, b} of head entry
- pass_cnt  out  CNT_W  samples with a>b
- fail_cnt  out  CNT_W  samples with a<=b
- eq_cnt  out  CNT_W  samples with a==b
- overflow  out  1  sticky: at least one event was dropped
- fifo_count  out  $clog2(DEPTH)+1  entries currently held

## Operation
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Result codes: 2'b01 = pass (a>b), 2'b10 = equal (a==b), 2'b00 = fail (a<b). 2'b11 is the reset/clear value of the history register `last_code` and is never emitted.
- Comparison is unsigned and WIDTH bits wide.
- Counters, updated on each in_valid cycle:
  - pass_cnt increments when a>b.
  - fail_cnt increments when a<=b, so equal samples count as fail as well.
  - eq_cnt increments when a==b.
  - Each counter saturates at all-ones and never wraps.
- Event push: a push occurs when in_valid=1 and (code != last_code or code == equal). last_code updates to code on every in_valid cycle.
  - The first sample after reset or clear always pushes.
  - Repeated pass or fail samples push only once. Every equal sample pushes.
- FIFO: DEPTH entries, circular, show-ahead.
  - out_data is the head entry. out_valid = (fifo_count != 0).
  - A pop occurs when out_valid && out_ready.
  - out_data is don't-care while out_valid=0.
- Full: a push with no simultaneous pop is dropped, and overflow is set.
  - A push and a pop in the same cycle while full are both accepted; fifo_count stays DEPTH.
- Empty: out_ready is ignored.
  - Push and pop in the same cycle with fifo_count=0 is not possible, because out_valid=0. The push is accepted and fifo_count becomes 1.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. fifo_count is tracked separately.
- State machine:
  - IDLE: after reset or clear; no sample seen yet.
  - TRACK: entered on the first in_valid.
  - OVF: entered on a dropped push. Exited only by clear or rst.
  - overflow = (state == OVF).
  - Pushes that have room are still accepted in OVF.
- clear (synchronous) returns the block to IDLE:
  - zeroes all counters;
  - sets last_code to 2'b11;
  - empties the FIFO;
  - clears overflow.
- clear priority: clear beats in_valid and pop in the same cycle. That sample is discarded and no counter changes.

## Timing
- Reset values: out_valid=0, out_data=0, pass_cnt=fail_cnt=eq_cnt=0, overflow=0, fifo_count=0, state=IDLE, last_code=2'b11.
- rst asserted mid-operation clears everything immediately and asynchronously, including FIFO contents.
- All outputs are registered or decoded from registers; no combinational path from the inputs to the outputs.
- Counters reflect a sample one cycle after the edge that samples it.
- Push latency: a sample at edge N into an empty FIFO gives out_valid=1 with that entry after edge N, i.e. visible in cycle N+1.
- Pop: an entry popped at edge N is replaced by the next entry, or out_valid drops, after edge N.
- Throughput: one push and one pop per cycle maximum.

## Test plan
- Reset then 3 in_valid samples (a=5,b=3) -> pass_cnt=3, fail_cnt=0, eq_cnt=0; exactly one entry {01,5,3}; fifo_count=1.
- Samples (2,2), (2,2), (1,4) with out_ready=0 -> eq_cnt=2, fail_cnt=3; FIFO holds {10,2,2}, {10,2,2}, {00,1,4} in order.
- out_ready=0, 6 alternating pass/fail samples, DEPTH=4 -> fifo_count=4, overflow=1 after the 5th sample. Draining then yields the first 4 events only.
- FIFO full, in_valid with a new code and out_ready=1 in the same cycle -> fifo_count stays 4, head advances, new event appears at the tail, overflow unchanged.
- 260 samples (9,1) with CNT_W=8 -> pass_cnt saturates at 255.
- clear asserted together with in_valid (0,0) while the FIFO holds entries -> next cycle all counters 0, fifo_count=0, overflow=0, state IDLE. The next (0,0) sample pushes.
- rst pulse mid-drain -> out_valid=0 and counts 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ab_compare_tracker.sv
// ab_compare_tracker
// Classifies each valid a/b sample as pass (a>b), equal (a==b) or fail (a<b).
// Keeps saturating statistics on the samples.
// Logs change-of-result and equality events into a show-ahead FIFO, which is
// drained over a valid/ready handshake.
module ab_compare_tracker #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH+1:0]       out_data,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         eq_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int DATA_W = 2 * WIDTH + 2;

  localparam logic [1:0] CODE_FAIL = 2'b00;
  localparam logic [1:0] CODE_PASS = 2'b01;
  localparam logic [1:0] CODE_EQ   = 2'b10;
  localparam logic [1:0] CODE_NONE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_OVF   = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [1:0]           r_last_code;
  logic [CNT_W-1:0]     r_pass_cnt;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic [CNT_W-1:0]     r_eq_cnt;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [FCNT_W-1:0]    r_count;

  logic [1:0]           w_code;
  logic                 w_sample;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [DATA_W-1:0]    w_entry;

  // Classify the current operands; equality is checked first so that
  // the pass/fail split only sees strictly ordered operands.
  always_comb begin
    w_code = CODE_FAIL;
    if (a == b) begin
      w_code = CODE_EQ;
    end else if (a > b) begin
      w_code = CODE_PASS;
    end
  end

  // Clear overrides everything in its cycle: the sample and any pop are discarded.
  assign w_sample   = in_valid & ~clear;
  assign w_pop      = out_valid & out_ready & ~clear;
  assign w_full     = (r_count == FCNT_W'(DEPTH));
  assign w_push_req = w_sample & ((w_code != r_last_code) | (w_code == CODE_EQ));
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_entry    = {w_code, a, b};

  // State register for the tracking FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // OVF is sticky until clear; the first sample moves IDLE to TRACK
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else if (w_drop) begin
      w_next_state = S_OVF;
    end else if ((r_state == S_IDLE) && in_valid) begin
      w_next_state = S_TRACK;
    end
  end

  // History of the last classified sample, used to detect result changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_code <= CODE_NONE;
    end else if (clear) begin
      r_last_code <= CODE_NONE;
    end else if (w_sample) begin
      r_last_code <= w_code;
    end
  end

  // Saturating statistics; equal samples count as fail too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_eq_cnt   <= '0;
    end else if (clear) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_eq_cnt   <= '0;
    end else if (w_sample) begin
      if ((w_code == CODE_PASS) && (r_pass_cnt != {CNT_W{1'b1}})) begin
        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
      if ((w_code != CODE_PASS) && (r_fail_cnt != {CNT_W{1'b1}})) begin
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      end
      if ((w_code == CODE_EQ) && (r_eq_cnt != {CNT_W{1'b1}})) begin
        r_eq_cnt <= r_eq_cnt + CNT_W'(1);
      end
    end
  end

  // Event storage; entries are zeroed on reset so the head reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Circular pointers wrap naturally; occupancy is tracked in its own counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + FCNT_W'(1);
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - FCNT_W'(1);
      end
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign eq_cnt     = r_eq_cnt;
  assign overflow   = (r_state == S_OVF);
  assign fifo_count = r_count;

endmodule
